// File: rtl/riscv_test_checker_pkg.sv
// Shared definitions for the riscv-tests pass/fail checker: state encoding,
// default register indices, magic values and a saturating increment helper.
package riscv_test_checker_pkg;

    // Checker states; the terminal states are PASS, FAIL and TOUT.
    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_SETTLE = 3'd1,
        ST_PASS   = 3'd2,
        ST_FAIL   = 3'd3,
        ST_TOUT   = 3'd4
    } state_t;

    // Register indices used by the riscv-tests environment.
    localparam int unsigned DEF_TNUM_REG = 3;
    localparam int unsigned DEF_DONE_REG = 26;
    localparam int unsigned DEF_PASS_REG = 27;

    // x27 holds this value when the test passed; x26 takes it to signal done.
    localparam logic [31:0] PASS_MAGIC = 32'd1;
    localparam logic [31:0] DONE_VALUE = 32'd1;

    // 32-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/riscv_test_checker.sv
// Snoops the register-file write-back port of the CPU, shadows the test
// number and pass flag, and issues a sticky PASS / FAIL / TIMEOUT verdict a
// fixed settle window after the program writes 1 to the done register.
module riscv_test_checker
    import riscv_test_checker_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 10,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned DONE_REG       = DEF_DONE_REG,
    parameter int unsigned PASS_REG       = DEF_PASS_REG,
    parameter int unsigned TNUM_REG       = DEF_TNUM_REG
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    output logic        test_done,
    output logic        test_pass,
    output logic        test_fail,
    output logic        test_timeout,
    output logic [31:0] fail_tnum,
    output logic [31:0] cycle_cnt
);

    localparam int SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    // Counter values seen on the edge that ends the window.
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TOUT_LAST   = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [4:0] DONE_IDX = 5'(DONE_REG);
    localparam logic [4:0] PASS_IDX = 5'(PASS_REG);
    localparam logic [4:0] TNUM_IDX = 5'(TNUM_REG);

    state_t         state;
    logic [31:0]    pass_shadow;
    logic [31:0]    tnum_shadow;
    logic [SW-1:0]  settle_cnt;
    logic [TW-1:0]  tout_cnt;

    // Decode of the write-back port; writes to x0 never count. The done
    // flag needs no shadow of its own: the RUN->SETTLE transition acts on
    // the write itself, and later done writes are deliberately ignored.
    logic wr_live;
    logic done_hit;
    assign wr_live  = wb_we && (wb_waddr != 5'd0);
    assign done_hit = wr_live && (wb_waddr == DONE_IDX) && (wb_wdata == DONE_VALUE);

    // State machine, shadows, counters and registered verdict outputs.
    // NOTE: every register here uses <= so all reads in this block see the
    // pre-edge value; the verdict must sample the pass shadow as it was
    // before the verdict edge, not a write landing on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            pass_shadow  <= '0;
            tnum_shadow  <= '0;
            settle_cnt   <= '0;
            tout_cnt     <= '0;
            cycle_cnt    <= '0;
            fail_tnum    <= '0;
            test_done    <= 1'b0;
            test_pass    <= 1'b0;
            test_fail    <= 1'b0;
            test_timeout <= 1'b0;
        end else if (clr) begin
            state        <= ST_RUN;
            pass_shadow  <= '0;
            tnum_shadow  <= '0;
            settle_cnt   <= '0;
            tout_cnt     <= '0;
            cycle_cnt    <= '0;
            fail_tnum    <= '0;
            test_done    <= 1'b0;
            test_pass    <= 1'b0;
            test_fail    <= 1'b0;
            test_timeout <= 1'b0;
        end else begin
            // Shadows and the run-time counter live only while undecided.
            if (state == ST_RUN || state == ST_SETTLE) begin
                cycle_cnt <= sat_inc(cycle_cnt);
                if (wr_live && wb_waddr == PASS_IDX) pass_shadow <= wb_wdata;
                if (wr_live && wb_waddr == TNUM_IDX) tnum_shadow <= wb_wdata;
            end

            unique case (state)
                ST_RUN: begin
                    tout_cnt <= tout_cnt + TW'(1);
                    // A done write on the timeout edge still wins.
                    if (done_hit) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end else if (tout_cnt == TOUT_LAST) begin
                        state        <= ST_TOUT;
                        test_done    <= 1'b1;
                        test_timeout <= 1'b1;
                        fail_tnum    <= tnum_shadow;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + SW'(1);
                    if (settle_cnt == SETTLE_LAST) begin
                        test_done <= 1'b1;
                        fail_tnum <= tnum_shadow;
                        if (pass_shadow == PASS_MAGIC) begin
                            state     <= ST_PASS;
                            test_pass <= 1'b1;
                        end else begin
                            state     <= ST_FAIL;
                            test_fail <= 1'b1;
                        end
                    end
                end
                default: begin
                    // Terminal states hold everything until reset or clr.
                end
            endcase
        end
    end

endmodule
